roc_sort_encoder: RTL and testbench

Parametrised rank-order-coding encoder that counting-sorts a pixel frame by intensity and streams pixel indices over a valid/ready AER link. Supports selectable order (brightest-first or darkest-first), a minimum-intensity threshold and an event cap. Sits between the image source and the AER input controller of the SNN core; it is the successor of the fixed 256-pixel, 8-bit, busy-handshake encoder.

---
 rtl/roc_pkg.sv | 19 +
 rtl/roc_sort_encoder_if.sv | 14 +
 rtl/roc_count_mem.sv | 23 ++
 rtl/roc_sort_encoder.sv | 241 ++++++++++++++++++++++++
 tb/tb_roc_sort_encoder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/roc_pkg.sv
// Shared types for the rank-order-coding sort encoder: FSM states and emission order.
package roc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    HIST,
    PREFIX,
    PLACE,
    PREAMBLE,
    EMIT
  } state_t;

  typedef enum logic {
    ORD_DESC,
    ORD_ASC
  } order_t;

endpackage

// File: rtl/roc_sort_encoder_if.sv
// AER output link of the sort encoder.
interface roc_sort_encoder_if #(
  parameter int AER_BITS = 10
);
  // A word moves on any edge where OUT_VALID && OUT_READY; once OUT_VALID rises,
  // OUT_ADDR/OUT_LAST hold until that edge, and OUT_VALID never drops without a transfer.
  logic                OUT_VALID;
  logic                OUT_READY;
  logic [AER_BITS-1:0] OUT_ADDR;
  logic                OUT_LAST;

  modport master (output OUT_VALID, output OUT_ADDR, output OUT_LAST, input OUT_READY);
  modport slave  (input OUT_VALID, input OUT_ADDR, input OUT_LAST, output OUT_READY);
endinterface

// File: rtl/roc_count_mem.sv
// Per-intensity counter array: one combinational read port, one synchronous write port.
module roc_count_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 9
) (
  input  logic          CLK,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[rd_addr];

  always_ff @(posedge CLK) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/roc_sort_encoder.sv
// Counting-sort rank-order encoder streaming pixel indices over AER.
// Define ROC_PREAMBLE_EN to send neuron-reset preamble events before each pixel stream.
module roc_sort_encoder
  import roc_pkg::*;
#(
  parameter int IMAGE_SIZE = 256,
  parameter int PIXEL_BITS = 8,
  parameter int AER_BITS   = 10
`ifdef ROC_PREAMBLE_EN
  ,
  parameter int                  PREAMBLE_EVENTS = 2,
  parameter logic [AER_BITS-1:0] PREAMBLE_ADDR   = 10'h1FF
`endif
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
  input  logic                                  NEW_IMAGE,
  input  logic                                  ORDER,
  input  logic [PIXEL_BITS-1:0]                 THRESHOLD,
  input  logic [$clog2(IMAGE_SIZE):0]           MAX_EVENTS,
  input  logic                                  STOP,
  roc_sort_encoder_if.master                    aer,
  output logic                                  SORT_DONE,
  output logic                                  ENCODER_RDY,
  output state_t                                dbg_state
);

  localparam int V  = 1 << PIXEL_BITS;
  localparam int CW = $clog2(IMAGE_SIZE) + 1;
  localparam int IW = (CW > 1) ? CW - 1 : 1;
  localparam int XW = (PIXEL_BITS > CW) ? PIXEL_BITS : CW;

  state_t                state_q, state_d;
  logic [XW-1:0]         idx_q, idx_d;
  order_t                order_q, order_d;
  logic [PIXEL_BITS-1:0] thr_q, thr_d;
  logic [CW-1:0]         max_q, max_d, sum_q, sum_d, npass_q, npass_d;
  logic [CW-1:0]         ptr_q, ptr_d, rem_q, rem_d;
  logic                  valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic [AER_BITS-1:0]   addr_q, addr_d;
`ifdef ROC_PREAMBLE_EN
  logic [15:0]           pre_q, pre_d;
`endif

  logic [IW-1:0]         sorted_q [IMAGE_SIZE];
  logic                  sorted_we;
  logic [IW-1:0]         sorted_wa, sorted_wd;

  logic [PIXEL_BITS-1:0] mem_ra, mem_wa, pix, pv;
  logic [CW-1:0]         mem_rd, mem_wd;
  logic                  mem_we, xfer, can_load;

  roc_count_mem #(.DEPTH(V), .AW(PIXEL_BITS), .DW(CW)) u_count_mem (
    .CLK     (CLK),
    .rd_addr (mem_ra),
    .rd_data (mem_rd),
    .we      (mem_we),
    .wr_addr (mem_wa),
    .wr_data (mem_wd)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    order_d   = order_q;
    thr_d     = thr_q;
    max_d     = max_q;
    sum_d     = sum_q;
    npass_d   = npass_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    last_d    = last_q;
    done_d    = 1'b0;
`ifdef ROC_PREAMBLE_EN
    pre_d     = pre_q;
`endif
    mem_ra    = '0;
    mem_we    = 1'b0;
    mem_wa    = '0;
    mem_wd    = '0;
    sorted_we = 1'b0;
    sorted_wa = '0;
    sorted_wd = '0;
    pix       = IMAGE[idx_q[IW-1:0]];
    // PREFIX walks intensities in emission order so the running sum is each bin's start slot.
    pv        = (order_q == ORD_DESC) ? ~idx_q[PIXEL_BITS-1:0] : idx_q[PIXEL_BITS-1:0];
    xfer      = valid_q & aer.OUT_READY;
    can_load  = ~valid_q | xfer;

    case (state_q)
      IDLE: begin
        if (NEW_IMAGE) begin
          state_d = CLEAR;
          idx_d   = '0;
          order_d = order_t'(ORDER);
          thr_d   = THRESHOLD;
          max_d   = MAX_EVENTS;
          sum_d   = '0;
          npass_d = '0;
        end
      end
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = idx_q[PIXEL_BITS-1:0];
        if (idx_q == XW'(V - 1)) begin
          idx_d   = '0;
          state_d = HIST;
        end else idx_d = idx_q + 1'b1;
      end
      HIST: begin
        mem_ra = pix;
        mem_we = 1'b1;
        mem_wa = pix;
        mem_wd = mem_rd + 1'b1;
        if (idx_q == XW'(IMAGE_SIZE - 1)) begin
          idx_d   = '0;
          state_d = PREFIX;
        end else idx_d = idx_q + 1'b1;
      end
      PREFIX: begin
        mem_ra = pv;
        mem_we = 1'b1;
        mem_wa = pv;
        mem_wd = sum_q;
        sum_d  = sum_q + mem_rd;
        if (pv >= thr_q) npass_d = npass_q + mem_rd;
        if (idx_q == XW'(V - 1)) begin
          idx_d   = '0;
          state_d = PLACE;
        end else idx_d = idx_q + 1'b1;
      end
      PLACE: begin
        // Ascending pixel index order here is what makes equal intensities stable.
        mem_ra    = pix;
        mem_we    = 1'b1;
        mem_wa    = pix;
        mem_wd    = mem_rd + 1'b1;
        sorted_we = 1'b1;
        sorted_wa = mem_rd[IW-1:0];
        sorted_wd = idx_q[IW-1:0];
        rem_d     = (max_q != '0 && max_q < npass_q) ? max_q : npass_q;
        ptr_d     = (order_q == ORD_DESC) ? '0 : CW'(IMAGE_SIZE) - npass_q;
        if (idx_q == XW'(IMAGE_SIZE - 1)) begin
          idx_d  = '0;
          done_d = 1'b1;
`ifdef ROC_PREAMBLE_EN
          pre_d   = '0;
          state_d = PREAMBLE;
`else
          state_d = EMIT;
`endif
        end else idx_d = idx_q + 1'b1;
      end
`ifdef ROC_PREAMBLE_EN
      PREAMBLE: begin
        if (can_load) begin
          if (!STOP && pre_q < 16'(PREAMBLE_EVENTS)) begin
            valid_d = 1'b1;
            addr_d  = PREAMBLE_ADDR;
            last_d  = 1'b0;
            pre_d   = pre_q + 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = STOP ? IDLE : EMIT;
          end
        end
      end
`endif
      EMIT: begin
        if (can_load) begin
          if (!STOP && rem_q != '0) begin
            valid_d = 1'b1;
            addr_d  = AER_BITS'(sorted_q[ptr_q[IW-1:0]]);
            last_d  = (rem_q == CW'(1));
            ptr_d   = ptr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      order_q <= ORD_DESC;
      thr_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      npass_q <= '0;
      ptr_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      order_q <= order_d;
      thr_q   <= thr_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      npass_q <= npass_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

`ifdef ROC_PREAMBLE_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pre_q <= '0;
    else     pre_q <= pre_d;
  end
`endif

  always_ff @(posedge CLK) begin
    if (sorted_we) sorted_q[sorted_wa] <= sorted_wd;
  end

  assign aer.OUT_VALID = valid_q;
  assign aer.OUT_ADDR  = addr_q;
  assign aer.OUT_LAST  = last_q;
  assign SORT_DONE     = done_q;
  assign ENCODER_RDY   = (state_q == IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_roc_sort_encoder.sv
// Directed bench for roc_sort_encoder with N=4 pixels of 8 bits and hand-computed event streams.
module tb_roc_sort_encoder;
  import roc_pkg::*;

  localparam int N  = 4;
  localparam int PB = 8;
  localparam int AB = 10;
  localparam int CW = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [N-1:0][PB-1:0] image;
  logic              new_image, order, stop;
  logic [PB-1:0]     threshold;
  logic [CW-1:0]     max_events;
  logic              sort_done, encoder_rdy;
  state_t            dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [AB:0] exp_q[$];
  logic [AB:0] mon_exp;
  logic [AB-1:0] first_addr;

  roc_sort_encoder_if #(.AER_BITS(AB)) bus ();

  roc_sort_encoder #(.IMAGE_SIZE(N), .PIXEL_BITS(PB), .AER_BITS(AB)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IMAGE       (image),
    .NEW_IMAGE   (new_image),
    .ORDER       (order),
    .THRESHOLD   (threshold),
    .MAX_EVENTS  (max_events),
    .STOP        (stop),
    .aer         (bus),
    .SORT_DONE   (sort_done),
    .ENCODER_RDY (encoder_rdy),
    .dbg_state   (dbg_state)
  );

  // clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int a, input bit l);
    exp_q.push_back({l, AB'(a)});
  endtask

  task automatic push_pre();
`ifdef ROC_PREAMBLE_EN
    push(10'h1FF, 1'b0);
    push(10'h1FF, 1'b0);
`endif
  endtask

  task automatic set_cfg(input int p0, input int p1, input int p2, input int p3,
                         input bit ord, input int thr, input int mx);
    image[0]   = PB'(p0);
    image[1]   = PB'(p1);
    image[2]   = PB'(p2);
    image[3]   = PB'(p3);
    order      = ord;
    threshold  = PB'(thr);
    max_events = CW'(mx);
  endtask

  task automatic start_frame();
    int cnt;
    cnt = 0;
    new_image = 1'b1;
    tick();
    new_image = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      cnt++;
      if (sort_done) break;
    end
    check("sort_lat", 32'(cnt), 32'd520);
    tick();
    check("done_pulse", 32'(sort_done), 32'd0);
  endtask

  task automatic finish_frame();
    for (int i = 0; i < 200 && !encoder_rdy; i++) tick();
    check("rdy", 32'(encoder_rdy), 32'd1);
    check("idle_valid", 32'(bus.OUT_VALID), 32'd0);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard: every transfer is matched against the head of exp_q
  always @(negedge CLK) begin
    if (!RST && bus.OUT_VALID && bus.OUT_READY) begin
      if (exp_q.size() == 0) begin
        check("evt_extra", 32'({bus.OUT_LAST, bus.OUT_ADDR}), 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("evt", 32'({bus.OUT_LAST, bus.OUT_ADDR}), 32'(mon_exp));
      end
    end
  end

  initial begin
    image         = '0;
    new_image     = 1'b0;
    order         = 1'b0;
    stop          = 1'b0;
    threshold     = '0;
    max_events    = '0;
    bus.OUT_READY = 1'b1;
`ifdef ROC_PREAMBLE_EN
    first_addr = 10'h1FF;
`else
    first_addr = 10'd1;
`endif

    // reset
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", 32'(bus.OUT_VALID), 32'd0);
    check("rst_addr", 32'(bus.OUT_ADDR), 32'd0);
    check("rst_last", 32'(bus.OUT_LAST), 32'd0);
    check("rst_done", 32'(sort_done), 32'd0);
    check("rst_rdy", 32'(encoder_rdy), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    RST = 1'b0;
    tick();

    // brightest first, no threshold, no cap
    set_cfg(10, 200, 200, 0, 1'b0, 0, 0);
    push_pre(); push(1, 0); push(2, 0); push(0, 0); push(3, 1);
    start_frame(); finish_frame();

    // darkest first
    set_cfg(10, 200, 200, 0, 1'b1, 0, 0);
    push_pre(); push(3, 0); push(0, 0); push(1, 0); push(2, 1);
    start_frame(); finish_frame();

    // darkest first with threshold
    set_cfg(10, 200, 200, 0, 1'b1, 11, 0);
    push_pre(); push(1, 0); push(2, 1);
    start_frame(); finish_frame();

    // threshold plus cap of one
    set_cfg(10, 200, 200, 0, 1'b0, 11, 1);
    push_pre(); push(1, 1);
    start_frame(); finish_frame();

    // threshold excludes every pixel
    set_cfg(10, 200, 200, 0, 1'b0, 255, 0);
    push_pre();
    start_frame(); finish_frame();

    // all ties: stable order, capped at three
    set_cfg(5, 5, 5, 5, 1'b0, 5, 3);
    push_pre(); push(0, 0); push(1, 0); push(2, 1);
    start_frame(); finish_frame();

    // all ties below threshold
    set_cfg(5, 5, 5, 5, 1'b1, 6, 0);
    push_pre();
    start_frame(); finish_frame();

    // mixed frame, darkest first
    set_cfg(7, 3, 9, 3, 1'b1, 0, 0);
    push_pre(); push(1, 0); push(3, 0); push(0, 0); push(2, 1);
    start_frame(); finish_frame();

    // mixed frame, brightest first, cap two
    set_cfg(7, 3, 9, 3, 1'b0, 0, 2);
    push_pre(); push(2, 0); push(0, 1);
    start_frame(); finish_frame();

    // consumer stalls on the first event
    bus.OUT_READY = 1'b0;
    set_cfg(10, 200, 200, 0, 1'b0, 0, 0);
    push_pre(); push(1, 0); push(2, 0); push(0, 0); push(3, 1);
    start_frame();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.OUT_VALID), 32'd1);
      check("stall_addr", 32'(bus.OUT_ADDR), 32'(first_addr));
      tick();
    end
    bus.OUT_READY = 1'b1;
    finish_frame();

    // STOP after the first transfer, pending event still completes
    bus.OUT_READY = 1'b0;
    set_cfg(10, 200, 200, 0, 1'b0, 0, 0);
`ifdef ROC_PREAMBLE_EN
    push(10'h1FF, 0); push(10'h1FF, 0);
`else
    push(1, 0); push(2, 0);
`endif
    start_frame();
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
    stop = 1'b1;
    tick();
    check("stop_pending", 32'(bus.OUT_VALID), 32'd1);
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
    check("stop_rdy", 32'(encoder_rdy), 32'd1);
    check("stop_valid", 32'(bus.OUT_VALID), 32'd0);
    check("stop_drain", 32'(exp_q.size()), 32'd0);
    stop = 1'b0;
    bus.OUT_READY = 1'b1;
    tick();

    // normal frame after an aborted one
    set_cfg(10, 200, 200, 0, 1'b0, 0, 0);
    push_pre(); push(1, 0); push(2, 0); push(0, 0); push(3, 1);
    start_frame(); finish_frame();

    // STOP held through the sort: nothing emitted
    stop = 1'b1;
    set_cfg(10, 200, 200, 0, 1'b0, 0, 0);
    start_frame(); finish_frame();
    stop = 1'b0;

    // reset during PLACE
    set_cfg(10, 200, 200, 0, 1'b0, 0, 0);
    new_image = 1'b1;
    tick();
    new_image = 1'b0;
    for (int i = 0; i < 1000 && dbg_state != PLACE; i++) tick();
    check("reach_place", 32'(dbg_state), 32'(PLACE));
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.OUT_VALID), 32'd0);
    check("mid_rst_addr", 32'(bus.OUT_ADDR), 32'd0);
    check("mid_rst_last", 32'(bus.OUT_LAST), 32'd0);
    check("mid_rst_done", 32'(sort_done), 32'd0);
    check("mid_rst_rdy", 32'(encoder_rdy), 32'd1);
    tick();
    RST = 1'b0;
    repeat (20) tick();
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));

    // recovery after reset
    set_cfg(10, 200, 200, 0, 1'b0, 0, 0);
    push_pre(); push(1, 0); push(2, 0); push(0, 0); push(3, 1);
    start_frame(); finish_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
